ecc_scrub_arb: RTL and testbench
================================

ECC_SCRUB_ARB -- requirements
Module: ecc_scrub_arb

Interface
REQ-001 Parameter CW_W, default 13, stored codeword width (8 data + 5 SECDED).
REQ-002 Parameter SCRUB_INTERVAL, default 64, idle cycles between scrub reads; legal range 2..65535.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 scrub_en  in  1  enables background scrubbing.
REQ-006 fifo_mem_rd_en / fifo_mem_rd_addr  in  1/4  granted FIFO read request and address.
REQ-007 fifo_mem_wr_en / fifo_mem_wr_addr / fifo_mem_wr_data  in  1/4/CW_W  granted FIFO write request, address, encoded codeword.
REQ-008 dec_sec / dec_ded  in  1/1  decoder flags (single corrected / double detected) for data read in the previous cycle.
REQ-009 dec_cw_corr  in  CW_W  decoder corrected codeword.
REQ-010 mem_rd_en / mem_rd_addr  out  1/4  arbitrated memory read port.
REQ-011 mem_wr_en / mem_wr_addr / mem_wr_data  out  1/4/CW_W  arbitrated memory write port.
REQ-012 fifo_rd_valid  out  1  decoder output this cycle belongs to a FIFO read.
REQ-013 scrub_busy  out  1  high in any state other than IDLE.
REQ-014 scrub_corr_cnt / scrub_ded_cnt  out  8/8  saturating counts of scrub write-backs and scrub double errors.
REQ-015 scrub_ded_irq  out  1  one-cycle pulse per scrub double-error detection.

Function
REQ-016 Memory read latency SHALL be one cycle; decoder flags are valid the cycle after mem_rd_en.
REQ-017 FIFO requests SHALL have absolute priority and pass to the memory ports combinationally, unmodified, in the same cycle.
REQ-018 fifo_rd_valid SHALL equal fifo_mem_rd_en registered one cycle.
REQ-019 FSM states: IDLE, WAIT, ISSUE, CHECK, WRBK.
REQ-020 IDLE: scrub_en=1 -> WAIT, interval counter loaded with SCRUB_INTERVAL-1.
REQ-021 WAIT: counter decrements each cycle; at 0 -> ISSUE; scrub_en=0 -> IDLE.
REQ-022 ISSUE: scrub_en=0 -> IDLE with no read; fifo_mem_rd_en=1 -> stay (stall); else drive mem_rd_en=1, mem_rd_addr=scrub_addr -> CHECK.
REQ-023 Collision: any fifo_mem_wr_en with fifo_mem_wr_addr==scrub_addr in the ISSUE-grant cycle, CHECK, or WRBK SHALL abort the scrub: no count, no write-back, advance.
REQ-024 CHECK (no collision): dec_ded=1 -> scrub_ded_cnt+1, scrub_ded_irq=1, advance; dec_sec=1 -> capture dec_cw_corr, go WRBK; neither -> advance.
REQ-025 WRBK: collision -> abort; fifo_mem_wr_en=1 (other address) -> stay; else mem_wr_en=1, mem_wr_addr=scrub_addr, mem_wr_data=captured codeword, scrub_corr_cnt+1, advance.
REQ-026 Advance: scrub_addr <= scrub_addr+1 modulo 16 (15 wraps to 0); next state WAIT with counter reloaded if scrub_en=1, else IDLE.
REQ-027 scrub_en deassertion in CHECK or WRBK SHALL NOT abandon the operation; it completes, then IDLE.
REQ-028 Counters SHALL saturate at 255, never wrap.
REQ-029 Scrubber SHALL never drive a memory port in a cycle the FIFO drives it.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, scrub_addr 0, interval counter 0, captured codeword 0, both counters 0, fifo_rd_valid 0, scrub_busy 0, scrub_ded_irq 0, scrub mem_rd_en/mem_wr_en 0; reset mid-WRBK SHALL suppress the write-back.

Verification
REQ-031 scrub_en=1, no FIFO traffic, SCRUB_INTERVAL=4, decoder clean -> mem_rd_en pulses every 5 cycles, addresses 0,1,...,15,0; counters stay 0.
REQ-032 dec_sec=1 at addr 3, dec_cw_corr=0x1ABC -> next cycle mem_wr_en=1, addr 3, data 0x1ABC; scrub_corr_cnt=1.
REQ-033 fifo_mem_rd_en held high 10 cycles while in ISSUE -> no scrub read until first free cycle, fifo_rd_valid=1 for exactly those 10 decode cycles.
REQ-034 dec_sec at addr 5 with FIFO write to addr 5 during WRBK stall -> no scrub write, count unchanged, scrub_addr becomes 6.
REQ-035 300 consecutive scrub dec_ded events -> 300 irq pulses, scrub_ded_cnt=255.
REQ-036 rst_n asserted in WRBK -> no mem_wr_en, all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/ecc_scrub_arb_if.sv
// Memory-side bundle for the ECC scrub arbiter: granted FIFO requests, decoder
// feedback, and the arbitrated single-port memory read/write ports.
interface ecc_scrub_arb_if #(
    parameter int CW_W = 13
);
    logic            fifo_mem_rd_en;
    logic [3:0]      fifo_mem_rd_addr;
    logic            fifo_mem_wr_en;
    logic [3:0]      fifo_mem_wr_addr;
    logic [CW_W-1:0] fifo_mem_wr_data;
    logic            dec_sec;
    logic            dec_ded;
    logic [CW_W-1:0] dec_cw_corr;
    logic            mem_rd_en;
    logic [3:0]      mem_rd_addr;
    logic            mem_wr_en;
    logic [3:0]      mem_wr_addr;
    logic [CW_W-1:0] mem_wr_data;
    logic            fifo_rd_valid;

    modport slave (
        input  fifo_mem_rd_en, fifo_mem_rd_addr,
        input  fifo_mem_wr_en, fifo_mem_wr_addr, fifo_mem_wr_data,
        input  dec_sec, dec_ded, dec_cw_corr,
        output mem_rd_en, mem_rd_addr,
        output mem_wr_en, mem_wr_addr, mem_wr_data,
        output fifo_rd_valid
    );

    modport master (
        output fifo_mem_rd_en, fifo_mem_rd_addr,
        output fifo_mem_wr_en, fifo_mem_wr_addr, fifo_mem_wr_data,
        output dec_sec, dec_ded, dec_cw_corr,
        input  mem_rd_en, mem_rd_addr,
        input  mem_wr_en, mem_wr_addr, mem_wr_data,
        input  fifo_rd_valid
    );
endinterface

// File: rtl/ecc_scrub_arb.sv
// Background ECC scrubber sharing a 16-entry SECDED memory with a FIFO that
// always wins; the scrubber reads, checks, and writes back corrected words.
module ecc_scrub_arb #(
    parameter int CW_W           = 13,
    parameter int SCRUB_INTERVAL = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scrub_en,
    ecc_scrub_arb_if.slave        bus,
    output logic                  scrub_busy,
    output logic [7:0]            scrub_corr_cnt,
    output logic [7:0]            scrub_ded_cnt,
    output logic                  scrub_ded_irq
);

    typedef enum logic [2:0] {IDLE, WAIT, ISSUE, CHECK, WRBK} state_t;

    localparam logic [15:0] RELOAD = 16'(SCRUB_INTERVAL - 1);

    state_t          state;
    logic [3:0]      scrub_addr;
    logic [15:0]     wait_cnt;
    logic [CW_W-1:0] corr_cw;

    logic collide;
    logic grant;
    logic scrub_rd;
    logic scrub_wr;
    logic advance;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A FIFO write to the word under scrub makes any result we hold stale.
    assign collide  = bus.fifo_mem_wr_en && (bus.fifo_mem_wr_addr == scrub_addr);
    assign grant    = (state == ISSUE) && scrub_en && !bus.fifo_mem_rd_en;
    // A colliding grant cycle skips the read entirely and just moves on.
    assign scrub_rd = grant && !collide;
    assign scrub_wr = (state == WRBK) && !bus.fifo_mem_wr_en;

    always_comb begin
        advance = 1'b0;
        case (state)
            ISSUE:   advance = grant && collide;
            CHECK:   advance = collide || bus.dec_ded || !bus.dec_sec;
            WRBK:    advance = collide || !bus.fifo_mem_wr_en;
            default: advance = 1'b0;
        endcase
    end

    assign bus.mem_rd_en   = bus.fifo_mem_rd_en | scrub_rd;
    assign bus.mem_rd_addr = scrub_rd ? scrub_addr : bus.fifo_mem_rd_addr;
    assign bus.mem_wr_en   = bus.fifo_mem_wr_en | scrub_wr;
    assign bus.mem_wr_addr = scrub_wr ? scrub_addr : bus.fifo_mem_wr_addr;
    assign bus.mem_wr_data = scrub_wr ? corr_cw : bus.fifo_mem_wr_data;
    assign scrub_busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            scrub_addr        <= '0;
            wait_cnt          <= '0;
            corr_cw           <= '0;
            scrub_corr_cnt    <= '0;
            scrub_ded_cnt     <= '0;
            scrub_ded_irq     <= 1'b0;
            bus.fifo_rd_valid <= 1'b0;
        end else begin
            bus.fifo_rd_valid <= bus.fifo_mem_rd_en;
            scrub_ded_irq     <= 1'b0;
            case (state)
                IDLE: begin
                    if (scrub_en) begin
                        state    <= WAIT;
                        wait_cnt <= RELOAD;
                    end
                end
                WAIT: begin
                    // Leaving at count 1 makes the CHECK cycle part of the idle gap.
                    if (!scrub_en) begin
                        state <= IDLE;
                    end else if (wait_cnt <= 16'd1) begin
                        state    <= ISSUE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - 16'd1;
                    end
                end
                ISSUE: begin
                    if (!scrub_en) begin
                        state <= IDLE;
                    end else if (scrub_rd) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (!collide) begin
                        if (bus.dec_ded) begin
                            scrub_ded_cnt <= sat_inc(scrub_ded_cnt);
                            scrub_ded_irq <= 1'b1;
                        end else if (bus.dec_sec) begin
                            corr_cw <= bus.dec_cw_corr;
                            state   <= WRBK;
                        end
                    end
                end
                WRBK: begin
                    if (scrub_wr) begin
                        scrub_corr_cnt <= sat_inc(scrub_corr_cnt);
                    end
                end
                default: state <= IDLE;
            endcase
            if (advance) begin
                scrub_addr <= scrub_addr + 4'd1;
                state      <= scrub_en ? WAIT : IDLE;
                wait_cnt   <= scrub_en ? RELOAD : '0;
            end
        end
    end

endmodule

// File: tb/tb_ecc_scrub_arb.sv
// Bench for ecc_scrub_arb: directed scenarios then random FIFO/decoder traffic,
// all cycles compared against a behavioural scrub-timeline model.
module tb_ecc_scrub_arb;

    localparam int CW_W = 13;
    localparam int IVL  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scrub_en;
    logic       scrub_busy;
    logic [7:0] scrub_corr_cnt;
    logic [7:0] scrub_ded_cnt;
    logic       scrub_ded_irq;

    ecc_scrub_arb_if #(.CW_W(CW_W)) bus ();

    ecc_scrub_arb #(.CW_W(CW_W), .SCRUB_INTERVAL(IVL)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .scrub_en       (scrub_en),
        .bus            (bus),
        .scrub_busy     (scrub_busy),
        .scrub_corr_cnt (scrub_corr_cnt),
        .scrub_ded_cnt  (scrub_ded_cnt),
        .scrub_ded_irq  (scrub_ded_irq)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Scrub timeline: off, counting down idle cycles, wanting a read slot,
    // reviewing a read result, or holding a corrected word to write back.
    bit              m_on, m_want, m_chk, m_wb, m_irq, m_rdv;
    int              m_wait, m_addr, m_corr, m_ded;
    logic [CW_W-1:0] m_wb_data;
    bit              srd_now;
    int              srd_addr_now;

    logic            o_rd_en, o_wr_en, o_rdv, o_irq, o_busy;
    logic [3:0]      o_rd_addr, o_wr_addr;
    logic [CW_W-1:0] o_wr_data;
    logic [7:0]      o_corr, o_ded;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        m_on = 0; m_want = 0; m_chk = 0; m_wb = 0; m_irq = 0; m_rdv = 0;
        m_wait = 0; m_addr = 0; m_corr = 0; m_ded = 0; m_wb_data = '0;
    endtask

    task automatic clear_inputs();
        bus.fifo_mem_rd_en   = 1'b0;
        bus.fifo_mem_rd_addr = '0;
        bus.fifo_mem_wr_en   = 1'b0;
        bus.fifo_mem_wr_addr = '0;
        bus.fifo_mem_wr_data = '0;
        bus.dec_sec          = 1'b0;
        bus.dec_ded          = 1'b0;
        bus.dec_cw_corr      = '0;
    endtask

    // Inputs are driven at posedge+1; checks happen at posedge+3, then the
    // model advances and the task returns at the next posedge+1.
    task automatic step();
        bit coll, srd, swr, adv, irq_n, frd, fwr, en, sec, ded;
        int fwa;
        logic [CW_W-1:0] cw;
        #2;
        frd = bus.fifo_mem_rd_en;  fwr = bus.fifo_mem_wr_en;
        fwa = int'(bus.fifo_mem_wr_addr);
        en  = scrub_en; sec = bus.dec_sec; ded = bus.dec_ded; cw = bus.dec_cw_corr;
        if (!rst_n) model_reset();
        coll = fwr && (fwa == m_addr);
        srd  = m_want && en && !frd && !coll;
        swr  = m_wb && !fwr;

        o_rd_en = bus.mem_rd_en;  o_rd_addr = bus.mem_rd_addr;
        o_wr_en = bus.mem_wr_en;  o_wr_addr = bus.mem_wr_addr;  o_wr_data = bus.mem_wr_data;
        o_rdv = bus.fifo_rd_valid; o_irq = scrub_ded_irq; o_busy = scrub_busy;
        o_corr = scrub_corr_cnt;  o_ded = scrub_ded_cnt;

        chk("mem_rd_en", 32'(o_rd_en), 32'(frd | srd));
        if (frd | srd)
            chk("mem_rd_addr", 32'(o_rd_addr), srd ? 32'(m_addr) : 32'(bus.fifo_mem_rd_addr));
        chk("mem_wr_en", 32'(o_wr_en), 32'(fwr | swr));
        if (fwr | swr) begin
            chk("mem_wr_addr", 32'(o_wr_addr), swr ? 32'(m_addr) : 32'(fwa));
            chk("mem_wr_data", 32'(o_wr_data), swr ? 32'(m_wb_data) : 32'(bus.fifo_mem_wr_data));
        end
        chk("scrub_busy", 32'(o_busy), 32'(m_on));
        chk("fifo_rd_valid", 32'(o_rdv), 32'(m_rdv));
        chk("scrub_ded_irq", 32'(o_irq), 32'(m_irq));
        chk("scrub_corr_cnt", 32'(o_corr), 32'(sat8(m_corr)));
        chk("scrub_ded_cnt", 32'(o_ded), 32'(sat8(m_ded)));
        srd_now = srd;
        srd_addr_now = m_addr;

        if (rst_n) begin
            irq_n = 0;
            adv   = 0;
            if (!m_on) begin
                if (en) begin m_on = 1; m_wait = IVL - 1; end
            end else if (m_want) begin
                if (!en) begin
                    m_want = 0; m_on = 0;
                end else if (!frd) begin
                    m_want = 0;
                    if (coll) adv = 1;
                    else m_chk = 1;
                end
            end else if (m_chk) begin
                m_chk = 0;
                if (coll) adv = 1;
                else if (ded) begin m_ded++; irq_n = 1; adv = 1; end
                else if (sec) begin m_wb = 1; m_wb_data = cw; end
                else adv = 1;
            end else if (m_wb) begin
                if (coll) begin m_wb = 0; adv = 1; end
                else if (!fwr) begin m_wb = 0; m_corr++; adv = 1; end
            end else begin
                if (!en) m_on = 0;
                else begin
                    m_wait--;
                    if (m_wait == 0) m_want = 1;
                end
            end
            if (adv) begin
                m_addr = (m_addr + 1) % 16;
                if (en) m_wait = IVL - 1;
                else m_on = 0;
            end
            m_irq = irq_n;
            m_rdv = frd;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nrd, last, found, nrv, nirq, ndrv;
        logic [3:0] faddr;

        rst_n = 1'b0;
        scrub_en = 1'b0;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Clean background scrub: one read every 5 cycles, walking addresses.
        scrub_en = 1'b1;
        nrd = 0;
        last = 0;
        for (int c = 0; c < 90; c++) begin
            step();
            if (o_rd_en === 1'b1) begin
                if (nrd > 0) chk("r031_gap", 32'(c - last), 32'd5);
                chk("r031_addr", 32'(o_rd_addr), 32'(nrd % 16));
                last = c;
                nrd++;
            end
        end
        chk("r031_wrapped", 32'(nrd >= 17), 32'd1);
        chk("r031_corr_zero", 32'(o_corr), 32'd0);
        chk("r031_ded_zero", 32'(o_ded), 32'd0);

        // Single-bit correction at address 3 is written back next cycle.
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            step();
            if (srd_now && srd_addr_now == 3) found = 1;
        end
        chk("r032_found", 32'(found), 32'd1);
        bus.dec_sec = 1'b1;
        bus.dec_cw_corr = 13'h1ABC;
        step();
        clear_inputs();
        step();
        chk("r032_wr_en", 32'(o_wr_en), 32'd1);
        chk("r032_wr_addr", 32'(o_wr_addr), 32'd3);
        chk("r032_wr_data", 32'(o_wr_data), 32'h1ABC);
        step();
        chk("r032_corr_cnt", 32'(o_corr), 32'd1);

        // FIFO reads hold off the scrubber for ten cycles.
        found = 0;
        for (int c = 0; c < 50 && found == 0; c++) begin
            if (m_want) found = 1;
            else step();
        end
        chk("r033_found", 32'(found), 32'd1);
        nrv = 0;
        for (int c = 0; c < 13; c++) begin
            faddr = 4'($urandom_range(0, 15));
            bus.fifo_mem_rd_en = (c < 10);
            bus.fifo_mem_rd_addr = faddr;
            step();
            if (c < 10) chk("r033_fifo_addr", 32'(o_rd_addr), 32'(faddr));
            if (c == 10) begin
                chk("r033_scrub_rd", 32'(o_rd_en), 32'd1);
                chk("r033_scrub_addr", 32'(o_rd_addr), 32'd4);
            end
            if (o_rdv === 1'b1) nrv++;
        end
        chk("r033_rdv_cycles", 32'(nrv), 32'd10);
        clear_inputs();

        // Write-back at address 5 stalled, then aborted by a FIFO write to 5.
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            step();
            if (srd_now && srd_addr_now == 5) found = 1;
        end
        chk("r034_found", 32'(found), 32'd1);
        bus.dec_sec = 1'b1;
        bus.dec_cw_corr = 13'h0F0F;
        step();
        clear_inputs();
        bus.fifo_mem_wr_en = 1'b1;
        bus.fifo_mem_wr_addr = 4'd9;
        bus.fifo_mem_wr_data = 13'h0123;
        step();
        chk("r034_stall_addr", 32'(o_wr_addr), 32'd9);
        chk("r034_stall_data", 32'(o_wr_data), 32'h0123);
        bus.fifo_mem_wr_addr = 4'd5;
        step();
        clear_inputs();
        step();
        chk("r034_corr_kept", 32'(o_corr), 32'd1);
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            step();
            if (o_rd_en === 1'b1) found = 1;
        end
        chk("r034_next_found", 32'(found), 32'd1);
        chk("r034_next_addr", 32'(o_rd_addr), 32'd6);

        // 300 double errors: one irq each, counter pins at 255.
        ndrv = 0;
        nirq = 0;
        for (int c = 0; c < 2000 && nirq < 300; c++) begin
            bus.dec_ded = m_chk && (ndrv < 300);
            if (bus.dec_ded) ndrv++;
            step();
            if (o_irq === 1'b1) nirq++;
        end
        chk("r035_irq_pulses", 32'(nirq), 32'd300);
        chk("r035_ded_cnt", 32'(o_ded), 32'd255);
        clear_inputs();

        // Random FIFO traffic, decoder flags and scrub_en toggling.
        for (int c = 0; c < 2000; c++) begin
            bus.fifo_mem_rd_en   = ($urandom_range(0, 3) == 0);
            bus.fifo_mem_rd_addr = 4'($urandom_range(0, 15));
            bus.fifo_mem_wr_en   = ($urandom_range(0, 3) == 0);
            bus.fifo_mem_wr_addr = ($urandom_range(0, 3) == 0) ? 4'(m_addr) : 4'($urandom_range(0, 15));
            bus.fifo_mem_wr_data = CW_W'($urandom);
            bus.dec_sec          = ($urandom_range(0, 2) == 0);
            bus.dec_ded          = ($urandom_range(0, 5) == 0);
            bus.dec_cw_corr      = CW_W'($urandom);
            if ($urandom_range(0, 39) == 0) scrub_en = ~scrub_en;
            step();
        end

        // Reset while a write-back is pending suppresses it immediately.
        clear_inputs();
        scrub_en = 1'b1;
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            if (m_chk) found = 1;
            else step();
        end
        chk("r036_found", 32'(found), 32'd1);
        bus.dec_sec = 1'b1;
        bus.dec_cw_corr = 13'h1555;
        step();
        clear_inputs();
        bus.fifo_mem_wr_en = 1'b1;
        bus.fifo_mem_wr_addr = 4'((m_addr + 1) % 16);
        step();
        clear_inputs();
        rst_n = 1'b0;
        step();
        chk("r036_wr_en", 32'(o_wr_en), 32'd0);
        chk("r036_busy", 32'(o_busy), 32'd0);
        chk("r036_corr", 32'(o_corr), 32'd0);
        chk("r036_ded", 32'(o_ded), 32'd0);
        chk("r036_irq", 32'(o_irq), 32'd0);
        chk("r036_rdv", 32'(o_rdv), 32'd0);
        rst_n = 1'b1;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
